// File: rtl/load_store_buffer_pkg.sv
// Shared definitions for the load/store buffer: queue sizing, ROB tag width,
// load/store instruction type codes (shared with dispatcher and RS), memory
// access size encodings, FSM state type and the per-entry record.
package load_store_buffer_pkg;

  localparam int LSB_SIZE_DEFAULT = 16;
  localparam int LSB_WIDTH        = $clog2(LSB_SIZE_DEFAULT);
  localparam int ROB_WIDTH        = 4;
  localparam int INST_TYPE_WIDTH  = 3;

  // Tag 0 is never allocated by the ROB; it marks an operand as available.
  localparam logic [ROB_WIDTH-1:0] ROB_NULL = '0;

  typedef enum logic [INST_TYPE_WIDTH-1:0] {
    INST_LB  = 3'd0,
    INST_LH  = 3'd1,
    INST_LW  = 3'd2,
    INST_LBU = 3'd3,
    INST_LHU = 3'd4,
    INST_SB  = 3'd5,
    INST_SH  = 3'd6,
    INST_SW  = 3'd7
  } inst_type_e;

  // Access size is carried as a plain byte count.
  localparam logic [2:0] MEM_SIZE_B = 3'd1;
  localparam logic [2:0] MEM_SIZE_H = 3'd2;
  localparam logic [2:0] MEM_SIZE_W = 3'd4;

  typedef enum logic {
    LSB_IDLE     = 1'b0,
    LSB_WAIT_MEM = 1'b1
  } lsb_state_e;

  typedef struct packed {
    logic [ROB_WIDTH-1:0] q;
    logic [31:0]          v;
  } operand_t;

  typedef struct packed {
    inst_type_e           inst;
    operand_t             j;     // base address operand
    operand_t             k;     // store data operand
    logic [31:0]          a;     // sign-extended offset
    logic [ROB_WIDTH-1:0] dest;
  } lsb_entry_t;

  function automatic logic is_store(input inst_type_e t);
    return (t == INST_SB) || (t == INST_SH) || (t == INST_SW);
  endfunction

  function automatic logic [2:0] mem_size(input inst_type_e t);
    case (t)
      INST_LB, INST_LBU, INST_SB: return MEM_SIZE_B;
      INST_LH, INST_LHU, INST_SH: return MEM_SIZE_H;
      default:                    return MEM_SIZE_W;
    endcase
  endfunction

  // Resolve a waiting operand against the ALU CDB and the load-buffer CDB.
  function automatic operand_t snoop(
    input operand_t             op,
    input logic                 alu_en,
    input logic [ROB_WIDTH-1:0] alu_dest,
    input logic [31:0]          alu_val,
    input logic                 lb_en,
    input logic [ROB_WIDTH-1:0] lb_dest,
    input logic [31:0]          lb_val
  );
    operand_t r;
    r = op;
    if (op.q != ROB_NULL) begin
      if (alu_en && (alu_dest == op.q)) begin
        r.v = alu_val;
        r.q = ROB_NULL;
      end else if (lb_en && (lb_dest == op.q)) begin
        r.v = lb_val;
        r.q = ROB_NULL;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/load_store_buffer_load_extend.sv
// Combinational size and sign/zero extension of raw load data.
// Ports:
//   inst_type_i  load instruction type of the head entry
//   data_i       raw memory data, already zero-extended by the controller
//   value_o      architecturally extended load result
module load_extend
  import load_store_buffer_pkg::*;
(
  input  inst_type_e  inst_type_i,
  input  logic [31:0] data_i,
  output logic [31:0] value_o
);

  always_comb begin
    value_o = data_i;
    case (inst_type_i)
      INST_LB:  value_o = {{24{data_i[7]}}, data_i[7:0]};
      INST_LH:  value_o = {{16{data_i[15]}}, data_i[15:0]};
      INST_LBU: value_o = {24'd0, data_i[7:0]};
      INST_LHU: value_o = {16'd0, data_i[15:0]};
      default:  value_o = data_i;
    endcase
  end

endmodule

// File: rtl/load_store_buffer.sv
// In-order load/store queue between dispatcher and memory controller.
// Entries snoop the ALU and load-buffer CDBs for operands; only the head
// entry is issued to memory. Stores issue only once the ROB has committed them.
// Load results are broadcast as a one-cycle pulse on the lbuffer CDB.
// Ports:
//   clk_in, rst_in (sync, active high), rdy_in (global stall)
//   rob_flush_in, rob_commit_store_*   ROB control
//   dispatcher_*, instqueue_rdy_out    entry allocation
//   cdb_alu_*                          ALU result broadcast (snooped)
//   mem_*                              memory request / completion
//   cdb_lbuffer_*                      load result broadcast
//
// state        | meaning
// -------------+------------------------------------------------------
// LSB_IDLE     | no request outstanding; head checked for issue
// LSB_WAIT_MEM | head entry issued; mem_en_out held until mem_done_in
module load_store_buffer
  import load_store_buffer_pkg::*;
#(
  parameter int LSB_SIZE = LSB_SIZE_DEFAULT
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       rdy_in,
  input  logic                       rob_flush_in,
  input  logic                       rob_commit_store_en_in,
  input  logic [ROB_WIDTH-1:0]       rob_commit_store_dest_in,
  output logic                       instqueue_rdy_out,
  input  logic                       dispatcher_en_in,
  input  logic [INST_TYPE_WIDTH-1:0] dispatcher_inst_type_in,
  input  logic [31:0]                dispatcher_vj_in,
  input  logic [31:0]                dispatcher_vk_in,
  input  logic [ROB_WIDTH-1:0]       dispatcher_qj_in,
  input  logic [ROB_WIDTH-1:0]       dispatcher_qk_in,
  input  logic [31:0]                dispatcher_A_in,
  input  logic [ROB_WIDTH-1:0]       dispatcher_dest_in,
  input  logic                       cdb_alu_en_in,
  input  logic [ROB_WIDTH-1:0]       cdb_alu_dest_in,
  input  logic [31:0]                cdb_alu_value_in,
  output logic                       mem_en_out,
  output logic                       mem_wr_out,
  output logic [31:0]                mem_addr_out,
  output logic [2:0]                 mem_size_out,
  output logic [31:0]                mem_data_out,
  input  logic                       mem_done_in,
  input  logic [31:0]                mem_data_in,
  output logic                       cdb_lbuffer_en_out,
  output logic [ROB_WIDTH-1:0]       cdb_lbuffer_dest_out,
  output logic [31:0]                cdb_lbuffer_value_out
);

  localparam int PTR_W = $clog2(LSB_SIZE);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(LSB_SIZE);
  localparam logic [CNT_W-1:0] RDY_LIMIT = CNT_W'(LSB_SIZE - 1);

  lsb_state_e           state_q, state_d;
  logic [PTR_W-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [CNT_W-1:0]     ccnt_q, ccnt_d;   // committed stores at the front of the queue
  logic [LSB_SIZE-1:0]  busy_q, busy_d, committed_q, committed_d;
  lsb_entry_t           entry_q [LSB_SIZE];
  lsb_entry_t           entry_d [LSB_SIZE];

  logic                 mem_en_q, mem_en_d, mem_wr_q, mem_wr_d;
  logic [31:0]          mem_addr_q, mem_addr_d, mem_data_q, mem_data_d;
  logic [2:0]           mem_size_q, mem_size_d;
  logic                 cdb_en_q, cdb_en_d;
  logic [ROB_WIDTH-1:0] cdb_dest_q, cdb_dest_d;
  logic [31:0]          cdb_value_q, cdb_value_d;

  lsb_entry_t           head_e, new_entry;
  logic                 head_is_store;
  logic [PTR_W-1:0]     commit_tail;
  logic                 push, pop, pop_committed, commit_hit;
  logic [31:0]          ext_value;

  // Committed stores always sit contiguously at the head, so the commit
  // pointer is derived from head and the committed count.
  assign head_e        = entry_q[head_q];
  assign head_is_store = is_store(head_e.inst);
  assign commit_tail   = head_q + PTR_W'(ccnt_q);

  assign push = dispatcher_en_in && (count_q != FULL_CNT) && !rob_flush_in;

  assign commit_hit = rob_commit_store_en_in && !rob_flush_in &&
                      (ccnt_q < count_q) && busy_q[commit_tail] &&
                      is_store(entry_q[commit_tail].inst) &&
                      (entry_q[commit_tail].dest == rob_commit_store_dest_in);

  load_extend u_load_extend (
    .inst_type_i (head_e.inst),
    .data_i      (mem_data_in),
    .value_o     (ext_value)
  );

  always_comb begin
    new_entry.inst = inst_type_e'(dispatcher_inst_type_in);
    new_entry.j    = snoop({dispatcher_qj_in, dispatcher_vj_in},
                           cdb_alu_en_in, cdb_alu_dest_in, cdb_alu_value_in,
                           cdb_en_q, cdb_dest_q, cdb_value_q);
    new_entry.k    = snoop({dispatcher_qk_in, dispatcher_vk_in},
                           cdb_alu_en_in, cdb_alu_dest_in, cdb_alu_value_in,
                           cdb_en_q, cdb_dest_q, cdb_value_q);
    new_entry.a    = dispatcher_A_in;
    new_entry.dest = dispatcher_dest_in;
  end

  always_comb begin
    state_d       = state_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    ccnt_d        = ccnt_q;
    busy_d        = busy_q;
    committed_d   = committed_q;
    entry_d       = entry_q;
    mem_en_d      = mem_en_q;
    mem_wr_d      = mem_wr_q;
    mem_addr_d    = mem_addr_q;
    mem_size_d    = mem_size_q;
    mem_data_d    = mem_data_q;
    cdb_en_d      = 1'b0;
    cdb_dest_d    = cdb_dest_q;
    cdb_value_d   = cdb_value_q;
    pop           = 1'b0;
    pop_committed = 1'b0;

    for (int i = 0; i < LSB_SIZE; i++) begin
      if (busy_q[i]) begin
        entry_d[i].j = snoop(entry_q[i].j, cdb_alu_en_in, cdb_alu_dest_in,
                             cdb_alu_value_in, cdb_en_q, cdb_dest_q, cdb_value_q);
        entry_d[i].k = snoop(entry_q[i].k, cdb_alu_en_in, cdb_alu_dest_in,
                             cdb_alu_value_in, cdb_en_q, cdb_dest_q, cdb_value_q);
      end
    end

    case (state_q)
      LSB_IDLE: begin
        if (busy_q[head_q]) begin
          if (!head_is_store && (head_e.j.q == ROB_NULL) && !rob_flush_in) begin
            mem_en_d   = 1'b1;
            mem_wr_d   = 1'b0;
            mem_addr_d = head_e.j.v + head_e.a;
            mem_size_d = mem_size(head_e.inst);
            state_d    = LSB_WAIT_MEM;
          end else if (head_is_store && committed_q[head_q] &&
                       (head_e.j.q == ROB_NULL) && (head_e.k.q == ROB_NULL)) begin
            mem_en_d   = 1'b1;
            mem_wr_d   = 1'b1;
            mem_addr_d = head_e.j.v + head_e.a;
            mem_size_d = mem_size(head_e.inst);
            mem_data_d = head_e.k.v;
            state_d    = LSB_WAIT_MEM;
          end
        end
      end
      LSB_WAIT_MEM: begin
        if (head_is_store) begin
          // Committed stores survive a flush and finish normally.
          if (mem_done_in) begin
            mem_en_d      = 1'b0;
            state_d       = LSB_IDLE;
            pop           = 1'b1;
            pop_committed = 1'b1;
          end
        end else if (rob_flush_in) begin
          // The load is discarded along with the rest of the uncommitted tail.
          mem_en_d = 1'b0;
          state_d  = LSB_IDLE;
        end else if (mem_done_in) begin
          mem_en_d    = 1'b0;
          state_d     = LSB_IDLE;
          pop         = 1'b1;
          cdb_en_d    = 1'b1;
          cdb_dest_d  = head_e.dest;
          cdb_value_d = ext_value;
        end
      end
      default: state_d = LSB_IDLE;
    endcase

    if (pop) begin
      busy_d[head_q]      = 1'b0;
      committed_d[head_q] = 1'b0;
      head_d              = head_q + PTR_W'(1);
    end

    if (commit_hit) begin
      committed_d[commit_tail] = 1'b1;
    end

    if (push) begin
      entry_d[tail_q]     = new_entry;
      busy_d[tail_q]      = 1'b1;
      committed_d[tail_q] = 1'b0;
      tail_d              = tail_q + PTR_W'(1);
    end

    ccnt_d  = ccnt_q + CNT_W'(commit_hit) - CNT_W'(pop_committed);
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    if (rob_flush_in) begin
      tail_d  = head_d + PTR_W'(ccnt_d);
      count_d = ccnt_d;
      for (int i = 0; i < LSB_SIZE; i++) begin
        if ({1'b0, PTR_W'(PTR_W'(i) - head_d)} >= ccnt_d) begin
          busy_d[i]      = 1'b0;
          committed_d[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= LSB_IDLE;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      ccnt_q      <= '0;
      busy_q      <= '0;
      committed_q <= '0;
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_size_q  <= '0;
      mem_data_q  <= '0;
      cdb_en_q    <= 1'b0;
      cdb_dest_q  <= ROB_NULL;
      cdb_value_q <= '0;
    end else if (rdy_in) begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      ccnt_q      <= ccnt_d;
      busy_q      <= busy_d;
      committed_q <= committed_d;
      mem_en_q    <= mem_en_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_size_q  <= mem_size_d;
      mem_data_q  <= mem_data_d;
      cdb_en_q    <= cdb_en_d;
      cdb_dest_q  <= cdb_dest_d;
      cdb_value_q <= cdb_value_d;
    end
  end

  // Entry payload is qualified by busy, so it needs no reset.
  always_ff @(posedge clk_in) begin
    if (rdy_in) begin
      entry_q <= entry_d;
    end
  end

  assign instqueue_rdy_out     = (count_q < RDY_LIMIT);
  assign mem_en_out            = mem_en_q;
  assign mem_wr_out            = mem_wr_q;
  assign mem_addr_out          = mem_addr_q;
  assign mem_size_out          = mem_size_q;
  assign mem_data_out          = mem_data_q;
  assign cdb_lbuffer_en_out    = cdb_en_q;
  assign cdb_lbuffer_dest_out  = cdb_dest_q;
  assign cdb_lbuffer_value_out = cdb_value_q;

endmodule

// File: tb/tb_load_store_buffer.sv
module tb_load_store_buffer;
  import load_store_buffer_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, rob_flush_in;
  logic        rob_commit_store_en_in;
  logic [3:0]  rob_commit_store_dest_in;
  logic        instqueue_rdy_out;
  logic        dispatcher_en_in;
  logic [2:0]  dispatcher_inst_type_in;
  logic [31:0] dispatcher_vj_in, dispatcher_vk_in, dispatcher_A_in;
  logic [3:0]  dispatcher_qj_in, dispatcher_qk_in, dispatcher_dest_in;
  logic        cdb_alu_en_in;
  logic [3:0]  cdb_alu_dest_in;
  logic [31:0] cdb_alu_value_in;
  logic        mem_en_out, mem_wr_out;
  logic [31:0] mem_addr_out, mem_data_out;
  logic [2:0]  mem_size_out;
  logic        mem_done_in;
  logic [31:0] mem_data_in;
  logic        cdb_lbuffer_en_out;
  logic [3:0]  cdb_lbuffer_dest_out;
  logic [31:0] cdb_lbuffer_value_out;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk_in = ~clk_in;

  load_store_buffer dut (
    .clk_in                  (clk_in),
    .rst_in                  (rst_in),
    .rdy_in                  (rdy_in),
    .rob_flush_in            (rob_flush_in),
    .rob_commit_store_en_in  (rob_commit_store_en_in),
    .rob_commit_store_dest_in(rob_commit_store_dest_in),
    .instqueue_rdy_out       (instqueue_rdy_out),
    .dispatcher_en_in        (dispatcher_en_in),
    .dispatcher_inst_type_in (dispatcher_inst_type_in),
    .dispatcher_vj_in        (dispatcher_vj_in),
    .dispatcher_vk_in        (dispatcher_vk_in),
    .dispatcher_qj_in        (dispatcher_qj_in),
    .dispatcher_qk_in        (dispatcher_qk_in),
    .dispatcher_A_in         (dispatcher_A_in),
    .dispatcher_dest_in      (dispatcher_dest_in),
    .cdb_alu_en_in           (cdb_alu_en_in),
    .cdb_alu_dest_in         (cdb_alu_dest_in),
    .cdb_alu_value_in        (cdb_alu_value_in),
    .mem_en_out              (mem_en_out),
    .mem_wr_out              (mem_wr_out),
    .mem_addr_out            (mem_addr_out),
    .mem_size_out            (mem_size_out),
    .mem_data_out            (mem_data_out),
    .mem_done_in             (mem_done_in),
    .mem_data_in             (mem_data_in),
    .cdb_lbuffer_en_out      (cdb_lbuffer_en_out),
    .cdb_lbuffer_dest_out    (cdb_lbuffer_dest_out),
    .cdb_lbuffer_value_out   (cdb_lbuffer_value_out)
  );

  typedef struct {
    logic [2:0]  inst;
    logic [31:0] vj, vk, a;
    logic [3:0]  dest;
    logic [31:0] rdata;
    logic [31:0] exp_addr;
    logic [2:0]  exp_size;
    logic        exp_wr;
    logic [31:0] exp_data;   // store data
    logic [31:0] exp_value;  // load broadcast value
  } vec_t;

  vec_t vecs[9];

  function automatic vec_t mk(input logic [2:0] inst, input logic [31:0] vj, vk, a,
                              input logic [3:0] dest, input logic [31:0] rdata, exp_addr,
                              input logic [2:0] exp_size, input logic exp_wr,
                              input logic [31:0] exp_data, exp_value);
    vec_t v;
    v.inst = inst; v.vj = vj; v.vk = vk; v.a = a; v.dest = dest; v.rdata = rdata;
    v.exp_addr = exp_addr; v.exp_size = exp_size; v.exp_wr = exp_wr;
    v.exp_data = exp_data; v.exp_value = exp_value;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic dispatch(input logic [2:0] inst, input logic [31:0] vj, vk, a,
                          input logic [3:0] qj, qk, dest);
    // Dispatching without room would break the dispatcher contract.
    check("dispatch_rdy", 32'(instqueue_rdy_out), 32'd1);
    dispatcher_inst_type_in = inst;
    dispatcher_vj_in = vj; dispatcher_vk_in = vk; dispatcher_A_in = a;
    dispatcher_qj_in = qj; dispatcher_qk_in = qk; dispatcher_dest_in = dest;
    dispatcher_en_in = 1'b1;
    tick();
    dispatcher_en_in = 1'b0;
  endtask

  task automatic commit(input logic [3:0] dest);
    rob_commit_store_en_in   = 1'b1;
    rob_commit_store_dest_in = dest;
    tick();
    rob_commit_store_en_in   = 1'b0;
  endtask

  task automatic wait_mem_en(input int max, input string name);
    int n = 0;
    while (mem_en_out !== 1'b1 && n < max) begin
      tick();
      n++;
    end
    check(name, 32'(mem_en_out), 32'd1);
  endtask

  // Two-cycle memory: hold one cycle, then pulse done with the data.
  task automatic mem_respond(input logic is_load, input logic [31:0] data,
                             input logic [3:0] dest, input logic [31:0] value,
                             input string name);
    tick();
    check({name, "_hold"}, 32'(mem_en_out), 32'd1);
    mem_data_in = data;
    mem_done_in = 1'b1;
    tick();
    mem_done_in = 1'b0;
    check({name, "_en_drop"}, 32'(mem_en_out), 32'd0);
    if (is_load) begin
      check({name, "_cdb_en"}, 32'(cdb_lbuffer_en_out), 32'd1);
      check({name, "_cdb_dest"}, 32'(cdb_lbuffer_dest_out), 32'(dest));
      check({name, "_cdb_value"}, cdb_lbuffer_value_out, value);
    end else begin
      check({name, "_no_cdb"}, 32'(cdb_lbuffer_en_out), 32'd0);
    end
    tick();
    check({name, "_cdb_pulse_end"}, 32'(cdb_lbuffer_en_out), 32'd0);
  endtask

  task automatic dep_load(input logic [2:0] inst, input logic [31:0] exp_val, input string name);
    dispatch(inst, 32'h0, 32'h0, 32'hFFFF_FFFF, 4'd5, 4'd0, 4'd4);
    tick(); tick(); tick();
    check({name, "_waits"}, 32'(mem_en_out), 32'd0);
    cdb_alu_en_in = 1'b1; cdb_alu_dest_in = 4'd5; cdb_alu_value_in = 32'h20;
    tick();
    cdb_alu_en_in = 1'b0;
    wait_mem_en(10, {name, "_issue"});
    check({name, "_addr"}, mem_addr_out, 32'h1F);
    check({name, "_size"}, 32'(mem_size_out), 32'd1);
    mem_respond(1'b1, 32'h80, 4'd4, exp_val, name);
  endtask

  task automatic watch_quiet(input int cycles, input string name);
    logic seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      seen = seen | mem_en_out | cdb_lbuffer_en_out;
    end
    check(name, 32'(seen), 32'd0);
  endtask

  initial begin
    vecs[0] = mk(INST_LW,  32'h1000,     32'h0,        32'h4,        4'd3, 32'hDEADBEEF,
                 32'h1004,     3'd4, 1'b0, 32'h0,        32'hDEADBEEF);
    vecs[1] = mk(INST_LB,  32'h20,       32'h0,        32'hFFFF_FFFF, 4'd5, 32'h80,
                 32'h1F,       3'd1, 1'b0, 32'h0,        32'hFFFFFF80);
    vecs[2] = mk(INST_LBU, 32'h20,       32'h0,        32'hFFFF_FFFF, 4'd6, 32'h80,
                 32'h1F,       3'd1, 1'b0, 32'h0,        32'h00000080);
    vecs[3] = mk(INST_LH,  32'h2000,     32'h0,        32'h2,        4'd1, 32'h8001,
                 32'h2002,     3'd2, 1'b0, 32'h0,        32'hFFFF8001);
    vecs[4] = mk(INST_LHU, 32'h2000,     32'h0,        32'h2,        4'd2, 32'hF00D,
                 32'h2002,     3'd2, 1'b0, 32'h0,        32'h0000F00D);
    vecs[5] = mk(INST_LW,  32'hFFFF_FFFC, 32'h0,       32'h8,        4'd8, 32'h12345678,
                 32'h4,        3'd4, 1'b0, 32'h0,        32'h12345678);
    vecs[6] = mk(INST_SW,  32'h3000,     32'hCAFEF00D, 32'h10,       4'd7, 32'h0,
                 32'h3010,     3'd4, 1'b1, 32'hCAFEF00D, 32'h0);
    vecs[7] = mk(INST_SB,  32'h40,       32'hAB,       32'h1,        4'd2, 32'h0,
                 32'h41,       3'd1, 1'b1, 32'hAB,       32'h0);
    vecs[8] = mk(INST_SH,  32'h100,      32'h1234,     32'hFFFF_FFFE, 4'd9, 32'h0,
                 32'hFE,       3'd2, 1'b1, 32'h1234,     32'h0);

    rst_in = 1'b1; rdy_in = 1'b1; rob_flush_in = 1'b0;
    rob_commit_store_en_in = 1'b0; rob_commit_store_dest_in = '0;
    dispatcher_en_in = 1'b0; dispatcher_inst_type_in = '0;
    dispatcher_vj_in = '0; dispatcher_vk_in = '0; dispatcher_A_in = '0;
    dispatcher_qj_in = '0; dispatcher_qk_in = '0; dispatcher_dest_in = '0;
    cdb_alu_en_in = 1'b0; cdb_alu_dest_in = '0; cdb_alu_value_in = '0;
    mem_done_in = 1'b0; mem_data_in = '0;
    tick(); tick();
    rst_in = 1'b0;
    check("reset_mem_en", 32'(mem_en_out), 32'd0);
    check("reset_cdb_en", 32'(cdb_lbuffer_en_out), 32'd0);
    check("reset_addr", mem_addr_out, 32'd0);
    check("reset_rdy", 32'(instqueue_rdy_out), 32'd1);

    // Single-entry transactions from the vector table.
    for (int i = 0; i < 9; i++) begin
      dispatch(vecs[i].inst, vecs[i].vj, vecs[i].vk, vecs[i].a, 4'd0, 4'd0, vecs[i].dest);
      if (vecs[i].exp_wr) commit(vecs[i].dest);
      wait_mem_en(20, $sformatf("vec%0d_issue", i));
      check($sformatf("vec%0d_addr", i), mem_addr_out, vecs[i].exp_addr);
      check($sformatf("vec%0d_size", i), 32'(mem_size_out), 32'(vecs[i].exp_size));
      check($sformatf("vec%0d_wr", i), 32'(mem_wr_out), 32'(vecs[i].exp_wr));
      if (vecs[i].exp_wr) check($sformatf("vec%0d_data", i), mem_data_out, vecs[i].exp_data);
      mem_respond(!vecs[i].exp_wr, vecs[i].rdata, vecs[i].dest, vecs[i].exp_value,
                  $sformatf("vec%0d", i));
    end

    // Loads whose base arrives later on the ALU CDB.
    dep_load(INST_LB,  32'hFFFFFF80, "dep_lb");
    dep_load(INST_LBU, 32'h00000080, "dep_lbu");

    // Ready store held back until the ROB commits it.
    dispatch(INST_SW, 32'h500, 32'h11223344, 32'h0, 4'd0, 4'd0, 4'd7);
    watch_quiet(10, "sw_uncommitted_quiet");
    commit(4'd7);
    check("sw_commit_not_yet", 32'(mem_en_out), 32'd0);
    tick();
    check("sw_issue_next", 32'(mem_en_out), 32'd1);
    check("sw_wr", 32'(mem_wr_out), 32'd1);
    check("sw_addr", mem_addr_out, 32'h500);
    check("sw_data", mem_data_out, 32'h11223344);
    mem_respond(1'b0, 32'h0, 4'd0, 32'h0, "sw");

    // Flush with a committed store in flight and three younger loads.
    dispatch(INST_SW, 32'h600, 32'h77, 32'h0, 4'd0, 4'd0, 4'd7);
    commit(4'd7);
    wait_mem_en(10, "fl_store_issue");
    dispatch(INST_LW, 32'h800, 32'h0, 32'h0, 4'd0, 4'd0, 4'd8);
    dispatch(INST_LW, 32'h900, 32'h0, 32'h0, 4'd0, 4'd0, 4'd9);
    dispatch(INST_LW, 32'hA00, 32'h0, 32'h0, 4'd0, 4'd0, 4'd10);
    rob_flush_in = 1'b1;
    tick();
    rob_flush_in = 1'b0;
    check("fl_store_kept", 32'(mem_en_out), 32'd1);
    check("fl_store_addr", mem_addr_out, 32'h600);
    mem_respond(1'b0, 32'h0, 4'd0, 32'h0, "fl_store");
    watch_quiet(8, "fl_loads_gone");
    check("fl_rdy", 32'(instqueue_rdy_out), 32'd1);

    // Flush abandons a load in flight; a dispatch in the flush cycle is dropped.
    dispatch(INST_LW, 32'h700, 32'h0, 32'h0, 4'd0, 4'd0, 4'd11);
    wait_mem_en(10, "ab_issue");
    rob_flush_in = 1'b1;
    dispatcher_inst_type_in = INST_LW; dispatcher_vj_in = 32'hB00;
    dispatcher_qj_in = 4'd0; dispatcher_dest_in = 4'd12; dispatcher_en_in = 1'b1;
    tick();
    rob_flush_in = 1'b0; dispatcher_en_in = 1'b0;
    check("ab_en_drop", 32'(mem_en_out), 32'd0);
    mem_done_in = 1'b1; mem_data_in = 32'h5555;
    tick();
    mem_done_in = 1'b0;
    check("ab_no_cdb", 32'(cdb_lbuffer_en_out), 32'd0);
    watch_quiet(6, "ab_quiet");

    // Fill to 15 with uncommitted stores, then drain across the wrap point.
    for (int d = 1; d <= 15; d++) begin
      dispatch(INST_SW, 32'(d) << 8, 32'hA000_0000 | 32'(d), 32'h0, 4'd0, 4'd0, 4'(d));
      if (d == 14) check("fill14_rdy", 32'(instqueue_rdy_out), 32'd1);
    end
    check("fill15_rdy", 32'(instqueue_rdy_out), 32'd0);
    check("fill_no_issue", 32'(mem_en_out), 32'd0);
    for (int d = 1; d <= 15; d++) commit(4'(d));
    for (int d = 1; d <= 15; d++) begin
      wait_mem_en(10, $sformatf("drain%0d_issue", d));
      check($sformatf("drain%0d_addr", d), mem_addr_out, 32'(d) << 8);
      check($sformatf("drain%0d_data", d), mem_data_out, 32'hA000_0000 | 32'(d));
      mem_respond(1'b0, 32'h0, 4'd0, 32'h0, $sformatf("drain%0d", d));
    end
    check("drain_rdy", 32'(instqueue_rdy_out), 32'd1);

    // Operand bypass in the dispatch cycle.
    cdb_alu_en_in = 1'b1; cdb_alu_dest_in = 4'd9; cdb_alu_value_in = 32'h44;
    dispatch(INST_LW, 32'h0, 32'h0, 32'h100, 4'd9, 4'd0, 4'd13);
    cdb_alu_en_in = 1'b0;
    wait_mem_en(5, "byp_issue");
    check("byp_addr", mem_addr_out, 32'h144);
    mem_respond(1'b1, 32'h55, 4'd13, 32'h55, "byp");

    // Global stall freezes everything.
    dispatch(INST_LW, 32'hC00, 32'h0, 32'h0, 4'd0, 4'd0, 4'd14);
    rdy_in = 1'b0;
    tick(); tick(); tick(); tick();
    check("stall_hold", 32'(mem_en_out), 32'd0);
    rdy_in = 1'b1;
    tick();
    check("stall_release", 32'(mem_en_out), 32'd1);
    check("stall_addr", mem_addr_out, 32'hC00);
    mem_respond(1'b1, 32'hFEED, 4'd14, 32'hFEED, "stall");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
